// File: rtl/mac_rx_ifc.sv
// mac_rx_ifc: receive-side MAC interface.
// Sinks a 2-bit valid/ready dibit stream, packs dibits LSB-first into bytes,
// writes them to a byte packet buffer, rings a doorbell at end of frame and
// holds the buffer until the consumer releases it.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rx_axi_valid/data  dibit stream in (valid low ends a frame)
//   rx_axi_ready       sink ready (never backpressures after reset)
//   pktbuf_wr_en/addr/data  byte write port, address 0-based per frame
//   pktbuf_maxaddr     address of last byte of the completed frame
//   doorbell           1-cycle pulse, frame complete, buffer handed over
//   pkt_release        consumer done with buffer, returns ownership
//   frame_err          1-cycle pulse, frame discarded (overflow / partial byte)
module mac_rx_ifc #(
    parameter int unsigned MAX_BYTES = 1518,
    parameter int unsigned ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_axi_valid,
    input  logic [1:0]        rx_axi_data,
    output logic              rx_axi_ready,
    output logic              pktbuf_wr_en,
    output logic [ADDR_W-1:0] pktbuf_wr_addr,
    output logic [7:0]        pktbuf_wr_data,
    output logic [ADDR_W-1:0] pktbuf_maxaddr,
    output logic              doorbell,
    input  logic              pkt_release,
    output logic              frame_err
);

    // One extra bit so the byte counter can reach MAX_BYTES even when it equals 2**ADDR_W.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RX, S_HOLD, S_DROP} state_t;

    state_t            state_q, state_d;
    logic              prev_valid_q;
    logic              ready_q, ready_d;
    logic [1:0]        dibit_ctr_q, dibit_ctr_d;
    logic [CNT_W-1:0]  byte_ctr_q, byte_ctr_d;
    logic [5:0]        shift_q, shift_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] maxaddr_q, maxaddr_d;
    logic              doorbell_q, doorbell_d;
    logic              frame_err_q, frame_err_d;
    logic              beat;

    assign beat = rx_axi_valid & ready_q;

    // State and output registers; prev_valid resets high so a frame in flight is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_valid_q <= 1'b1;
            ready_q      <= 1'b0;
            dibit_ctr_q  <= '0;
            byte_ctr_q   <= '0;
            shift_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            maxaddr_q    <= '0;
            doorbell_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_valid_q <= rx_axi_valid;
            ready_q      <= ready_d;
            dibit_ctr_q  <= dibit_ctr_d;
            byte_ctr_q   <= byte_ctr_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            maxaddr_q    <= maxaddr_d;
            doorbell_q   <= doorbell_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b1;
        dibit_ctr_d = dibit_ctr_q;
        byte_ctr_d  = byte_ctr_q;
        shift_d     = shift_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        maxaddr_d   = maxaddr_q;
        doorbell_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only a rising valid starts a frame; tails of frames are never captured.
                if (beat && !prev_valid_q) begin
                    state_d     = S_RX;
                    shift_d     = {4'b0000, rx_axi_data};
                    dibit_ctr_d = 2'd1;
                    byte_ctr_d  = '0;
                end
            end
            S_RX: begin
                if (!rx_axi_valid) begin
                    if (dibit_ctr_q == 2'd0 && byte_ctr_q != '0) begin
                        doorbell_d = 1'b1;
                        maxaddr_d  = ADDR_W'(byte_ctr_q - CNT_W'(1));
                        state_d    = S_HOLD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else if (beat) begin
                    if (dibit_ctr_q == 2'd3) begin
                        dibit_ctr_d = 2'd0;
                        if (byte_ctr_q == CNT_W'(MAX_BYTES)) begin
                            frame_err_d = 1'b1;
                            state_d     = S_DROP;
                        end else begin
                            wr_en_d    = 1'b1;
                            wr_addr_d  = ADDR_W'(byte_ctr_q);
                            wr_data_d  = {rx_axi_data, shift_q};
                            byte_ctr_d = byte_ctr_q + CNT_W'(1);
                        end
                    end else begin
                        case (dibit_ctr_q)
                            2'd0:    shift_d[1:0] = rx_axi_data;
                            2'd1:    shift_d[3:2] = rx_axi_data;
                            default: shift_d[5:4] = rx_axi_data;
                        endcase
                        dibit_ctr_d = dibit_ctr_q + 2'd1;
                    end
                end
            end
            S_HOLD: begin
                // Releasing mid-frame must not resync onto the frame tail.
                if (pkt_release) begin
                    state_d = rx_axi_valid ? S_DROP : S_IDLE;
                end
            end
            default: begin
                if (!rx_axi_valid) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    assign rx_axi_ready   = ready_q;
    assign pktbuf_wr_en   = wr_en_q;
    assign pktbuf_wr_addr = wr_addr_q;
    assign pktbuf_wr_data = wr_data_q;
    assign pktbuf_maxaddr = maxaddr_q;
    assign doorbell       = doorbell_q;
    assign frame_err      = frame_err_q;

endmodule

// File: tb/tb_mac_rx_ifc.sv
// Testbench for mac_rx_ifc: cycle-exact vector table, hand-written corner
// sequences and randomized frames scored against a frame-level reference model.
module tb_mac_rx_ifc;

    localparam int unsigned MAX_BYTES = 1518;
    localparam int unsigned ADDR_W    = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_axi_valid;
    logic [1:0]        rx_axi_data;
    logic              rx_axi_ready;
    logic              pktbuf_wr_en;
    logic [ADDR_W-1:0] pktbuf_wr_addr;
    logic [7:0]        pktbuf_wr_data;
    logic [ADDR_W-1:0] pktbuf_maxaddr;
    logic              doorbell;
    logic              pkt_release;
    logic              frame_err;

    mac_rx_ifc #(.MAX_BYTES(MAX_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_axi_valid   (rx_axi_valid),
        .rx_axi_data    (rx_axi_data),
        .rx_axi_ready   (rx_axi_ready),
        .pktbuf_wr_en   (pktbuf_wr_en),
        .pktbuf_wr_addr (pktbuf_wr_addr),
        .pktbuf_wr_data (pktbuf_wr_data),
        .pktbuf_maxaddr (pktbuf_maxaddr),
        .doorbell       (doorbell),
        .pkt_release    (pkt_release),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Cycle table record: inputs for one cycle and outputs expected after its edge.
    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        rel;
        logic        we;
        logic [10:0] wa;
        logic [7:0]  wd;
        logic        db;
        logic        fe;
        logic [10:0] ma;
    } vec_t;

    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    // Monitor state, sampled on the falling edge.
    wr_t got_wr[$];
    int  got_db = 0, got_err = 0, cyc = 0, last_wr_cyc = -1;
    int  db_same_cnt = 0, both_cnt = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (pktbuf_wr_en) begin
            got_wr.push_back({pktbuf_wr_addr, pktbuf_wr_data});
            last_wr_cyc = cyc;
        end
        if (doorbell) begin
            got_db = got_db + 1;
            if (last_wr_cyc == cyc) db_same_cnt = db_same_cnt + 1;
        end
        if (frame_err) got_err = got_err + 1;
        if (doorbell && frame_err) both_cnt = both_cnt + 1;
    end

    // Reference model state.
    logic [1:0] frame_q[$];
    wr_t        exp_wr[$];
    int         exp_db, exp_err;
    int         exp_ma = 0;
    bit         held = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] d, input logic rel);
        rx_axi_valid = v;
        rx_axi_data  = d;
        pkt_release  = rel;
        tick();
    endtask

    task automatic clear_mon();
        got_wr.delete();
        got_db  = 0;
        got_err = 0;
    endtask

    // Frame-level model: what a whole frame of dibits should produce.
    task automatic model_frame();
        int n, nb, b;
        n  = frame_q.size();
        nb = n / 4;
        exp_wr.delete();
        exp_db  = 0;
        exp_err = 0;
        if (held) return;
        if (nb > int'(MAX_BYTES)) begin
            nb      = MAX_BYTES;
            exp_err = 1;
        end else if (n % 4 != 0) begin
            exp_err = 1;
        end else if (nb > 0) begin
            exp_db = 1;
            exp_ma = nb - 1;
            held   = 1;
        end
        for (int k = 0; k < nb; k++) begin
            b = int'(frame_q[4*k]) + 4 * int'(frame_q[4*k+1])
              + 16 * int'(frame_q[4*k+2]) + 64 * int'(frame_q[4*k+3]);
            exp_wr.push_back({11'(k), 8'(b)});
        end
    endtask

    task automatic rand_frame(input int n);
        frame_q.delete();
        for (int i = 0; i < n; i++) frame_q.push_back(2'($urandom_range(0, 3)));
    endtask

    // Send frame_q, end it, let outputs settle, compare against the model.
    task automatic run_frame_check(input string name);
        int bad;
        clear_mon();
        foreach (frame_q[i]) drive(1'b1, frame_q[i], 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        model_frame();
        chk({name, " nwr"}, got_wr.size(), exp_wr.size());
        bad = -1;
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
            if (bad < 0 && got_wr[i] != exp_wr[i]) bad = i;
        end
        n_cmp = n_cmp + 1;
        if (bad >= 0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s wrdata: idx %0d got a=%0d d=%02h expected a=%0d d=%02h", name, bad,
                     got_wr[bad].a, got_wr[bad].d, exp_wr[bad].a, exp_wr[bad].d);
        end
        chk({name, " doorbell"}, got_db, exp_db);
        chk({name, " frame_err"}, got_err, exp_err);
        chk({name, " maxaddr"}, int'(pktbuf_maxaddr), exp_ma);
    endtask

    task automatic release_buf();
        drive(1'b0, 2'd0, 1'b1);
        pkt_release = 1'b0;
        held = 0;
    endtask

    function automatic vec_t row(input logic v, input logic [1:0] d, input logic rel,
                                 input logic we, input logic [10:0] wa, input logic [7:0] wd,
                                 input logic db, input logic fe, input logic [10:0] ma);
        vec_t r;
        r.v = v; r.d = d; r.rel = rel; r.we = we; r.wa = wa; r.wd = wd;
        r.db = db; r.fe = fe; r.ma = ma;
        return r;
    endfunction

    vec_t tbl[26];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Dibits 0,1,2,3,3,2,1,0 -> E4, 1B; then 6-dibit partial frame; then 1-byte frame.
        tbl[0]  = row(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = row(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[2]  = row(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[3]  = row(1, 2, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[4]  = row(1, 3, 0, 1, 0, 8'hE4, 0, 0, 0);
        tbl[5]  = row(1, 3, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[6]  = row(1, 2, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[7]  = row(1, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        tbl[8]  = row(1, 0, 0, 1, 1, 8'h1B, 0, 0, 0);
        tbl[9]  = row(0, 0, 0, 0, 0, 8'h00, 1, 0, 1);
        tbl[10] = row(0, 0, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[11] = row(0, 0, 1, 0, 0, 8'h00, 0, 0, 1);
        tbl[12] = row(1, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[13] = row(1, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[14] = row(1, 1, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[15] = row(1, 1, 0, 1, 0, 8'h55, 0, 0, 1);
        tbl[16] = row(1, 2, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[17] = row(1, 3, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[18] = row(0, 0, 0, 0, 0, 8'h00, 0, 1, 1);
        tbl[19] = row(0, 0, 1, 0, 0, 8'h00, 0, 0, 1);
        tbl[20] = row(1, 2, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[21] = row(1, 2, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[22] = row(1, 2, 0, 0, 0, 8'h00, 0, 0, 1);
        tbl[23] = row(1, 2, 0, 1, 0, 8'hAA, 0, 0, 1);
        tbl[24] = row(0, 0, 0, 0, 0, 8'h00, 1, 0, 0);
        tbl[25] = row(0, 0, 1, 0, 0, 8'h00, 0, 0, 0);

        rst = 1'b1;
        rx_axi_valid = 1'b0;
        rx_axi_data  = 2'd0;
        pkt_release  = 1'b0;
        repeat (3) tick();
        chk("reset ready", int'(rx_axi_ready), 0);
        chk("reset wr_en", int'(pktbuf_wr_en), 0);
        chk("reset doorbell", int'(doorbell), 0);
        chk("reset frame_err", int'(frame_err), 0);
        chk("reset maxaddr", int'(pktbuf_maxaddr), 0);
        rst = 1'b0;
        tick();
        chk("ready after reset", int'(rx_axi_ready), 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].rel);
            chk($sformatf("tbl%0d wr_en", i), int'(pktbuf_wr_en), int'(tbl[i].we));
            chk($sformatf("tbl%0d doorbell", i), int'(doorbell), int'(tbl[i].db));
            chk($sformatf("tbl%0d frame_err", i), int'(frame_err), int'(tbl[i].fe));
            chk($sformatf("tbl%0d maxaddr", i), int'(pktbuf_maxaddr), int'(tbl[i].ma));
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d wr_addr", i), int'(pktbuf_wr_addr), int'(tbl[i].wa));
                chk($sformatf("tbl%0d wr_data", i), int'(pktbuf_wr_data), int'(tbl[i].wd));
            end
        end
        pkt_release = 1'b0;
        exp_ma = 0;
        held   = 0;

        // 60-byte frame, a second frame while held is dropped, release, then a new frame.
        rand_frame(240);
        run_frame_check("t2 first");
        rand_frame(40);
        run_frame_check("t2 held");
        release_buf();
        rand_frame(8);
        run_frame_check("t2 after release");
        release_buf();

        // Release while a frame is in flight: the rest of it must be ignored.
        rand_frame(8);
        run_frame_check("t3 first");
        clear_mon();
        repeat (6) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        drive(1'b1, 2'd1, 1'b1);
        held = 0;
        repeat (10) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        chk("t3 drop nwr", got_wr.size(), 0);
        chk("t3 drop doorbell", got_db, 0);
        chk("t3 drop frame_err", got_err, 0);
        rand_frame(4);
        run_frame_check("t3 fresh");
        release_buf();

        // Oversized frame: 1519 bytes.
        rand_frame(4 * (MAX_BYTES + 1));
        run_frame_check("t4 overflow");

        // 6-dibit frame: one write then frame_err.
        rand_frame(6);
        run_frame_check("t5 partial");

        // Reset in mid-frame, released with valid still high.
        clear_mon();
        repeat (10) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        rst = 1'b1;
        #1;
        chk("t6 rst wr_en", int'(pktbuf_wr_en), 0);
        chk("t6 rst doorbell", int'(doorbell), 0);
        chk("t6 rst ready", int'(rx_axi_ready), 0);
        exp_ma = 0;
        held   = 0;
        repeat (2) drive(1'b1, 2'd2, 1'b0);
        clear_mon();
        rst = 1'b0;
        repeat (20) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        drive(1'b0, 2'd0, 1'b0);
        chk("t6 tail nwr", got_wr.size(), 0);
        chk("t6 tail doorbell", got_db, 0);
        chk("t6 tail frame_err", got_err, 0);
        rand_frame(12);
        run_frame_check("t6 fresh");
        release_buf();

        // Randomized frames with random release behaviour.
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 9) < 7) rand_frame(4 * $urandom_range(1, 20));
            else rand_frame($urandom_range(1, 40));
            run_frame_check($sformatf("rnd%0d", f));
            if ($urandom_range(0, 3) != 0) release_buf();
        end

        chk("doorbell after last write", db_same_cnt, 0);
        chk("doorbell/frame_err exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
